// File: rtl/fetch_sequencer_if.sv
// Handshake and status bundle between the fetch sequencer, instruction memory and decoder.
// The master modport is the sequencer's view; slave is the memory/decoder/environment side.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              start;
  logic [ADDR_W+2:0] imem_rdata;
  logic              imem_ack;
  logic              pc_src;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              exec_en;
  logic              halted;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       instr_count;

  modport master (
    input  start, imem_rdata, imem_ack, pc_src,
    output imem_req, imem_addr, opcode, operand, exec_en, halted, pc, instr_count
  );

  modport slave (
    output start, imem_rdata, imem_ack, pc_src,
    input  imem_req, imem_addr, opcode, operand, exec_en, halted, pc, instr_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: owns PC, IR and the executed-instruction counter,
// fetching over a req/ack port and strobing one EXEC cycle per instruction.
module fetch_sequencer #(
  parameter int unsigned            ADDR_W     = 13,
  parameter logic [ADDR_W-1:0]      START_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  localparam int unsigned       IrW    = ADDR_W + 3;
  localparam logic [2:0]        OpHlt  = 3'b111;
  localparam logic [ADDR_W-1:0] PcOne  = ADDR_W'(1);
  localparam logic [15:0]       CntMax = 16'hFFFF;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [IrW-1:0]    r_ir;
  logic [IrW-1:0]    w_ir_next;
  logic [15:0]       r_count;
  logic [15:0]       w_count_next;
  logic [2:0]        w_opcode;
  logic [ADDR_W-1:0] w_operand;

  assign w_opcode  = r_ir[IrW-1:IrW-3];
  assign w_operand = r_ir[ADDR_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_next = StFetch;
      StFetch: if (bus.imem_ack) w_state_next = StExec;
      StExec:  w_state_next = (w_opcode == OpHlt) ? StHalt : StFetch;
      StHalt:  if (bus.start) w_state_next = StFetch;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath next values; each register only moves in the state that owns it
  always_comb begin
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_count_next = r_count;
    unique case (r_state)
      StIdle, StHalt: begin
        if (bus.start) begin
          w_pc_next    = START_ADDR;
          w_count_next = '0;
        end
      end
      StFetch: begin
        if (bus.imem_ack) w_ir_next = bus.imem_rdata;
      end
      StExec: begin
        w_count_next = (r_count == CntMax) ? r_count : r_count + 16'd1;
        if ((w_opcode != OpHlt) && bus.pc_src) begin
          w_pc_next = w_operand;
        end else begin
          w_pc_next = r_pc + PcOne;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_count <= '0;
    end else begin
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_count <= w_count_next;
    end
  end

  // Moore outputs
  always_comb begin
    bus.imem_req    = 1'b0;
    bus.exec_en     = 1'b0;
    bus.halted      = 1'b0;
    bus.imem_addr   = r_pc;
    bus.pc          = r_pc;
    bus.opcode      = w_opcode;
    bus.operand     = w_operand;
    bus.instr_count = r_count;
    unique case (r_state)
      StFetch: bus.imem_req = 1'b1;
      StExec:  bus.exec_en  = 1'b1;
      StHalt:  bus.halted   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table on one instance plus a
// hand-written wrap-around sequence on a second instance started at the top of memory.
module tb_fetch_sequencer;

  localparam int unsigned AW = 13;

  typedef struct {
    logic        rst;
    logic        start;
    logic        ack;
    logic [15:0] rdata;
    logic        pc_src;
    logic        exp_req;
    logic        exp_exec;
    logic        exp_halted;
    logic [12:0] exp_pc;
    logic [2:0]  exp_op;
    logic [12:0] exp_opnd;
    logic [15:0] exp_cnt;
  } vec_t;

  logic clk;
  logic rst;
  logic rst2;
  int   checks;
  int   errors;
  vec_t vecs[$];

  fetch_sequencer_if #(.ADDR_W(AW)) bus ();
  fetch_sequencer_if #(.ADDR_W(AW)) bus2 ();

  fetch_sequencer #(.ADDR_W(AW), .START_ADDR(13'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_sequencer #(.ADDR_W(AW), .START_ADDR(13'h1FFF)) dut_wrap (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic a, input logic [15:0] d,
                     input logic p, input logic req, input logic ex, input logic h,
                     input logic [12:0] pc, input logic [2:0] op, input logic [12:0] opnd,
                     input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.start = s; v.ack = a; v.rdata = d; v.pc_src = p;
    v.exp_req = req; v.exp_exec = ex; v.exp_halted = h; v.exp_pc = pc;
    v.exp_op = op; v.exp_opnd = opnd; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rst2 = 1'b1;
    bus.start = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.pc_src = 1'b0;
    bus2.start = 1'b0; bus2.imem_ack = 1'b0; bus2.imem_rdata = '0; bus2.pc_src = 1'b0;

    // rst start ack rdata pc_src | req exec halted pc op opnd cnt (outputs after the edge)
    add(1, 0, 0, 16'h0000, 0,  0, 0, 0, 13'h000, 3'd0, 13'h000, 16'd0);
    add(1, 0, 0, 16'h0000, 0,  0, 0, 0, 13'h000, 3'd0, 13'h000, 16'd0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 16'h0000, 0,  0, 0, 0, 13'h000, 3'd0, 13'h000, 16'd0);
    // Sequential program 0005, 4006, E000 (HLT), zero-wait
    add(0, 1, 0, 16'h0000, 0,  1, 0, 0, 13'h000, 3'd0, 13'h000, 16'd0);
    add(0, 0, 1, 16'h0005, 0,  0, 1, 0, 13'h000, 3'd0, 13'h005, 16'd0);
    add(0, 0, 0, 16'h0000, 0,  1, 0, 0, 13'h001, 3'd0, 13'h005, 16'd1);
    add(0, 0, 1, 16'h4006, 0,  0, 1, 0, 13'h001, 3'd2, 13'h006, 16'd1);
    add(0, 0, 0, 16'h0000, 0,  1, 0, 0, 13'h002, 3'd2, 13'h006, 16'd2);
    add(0, 0, 1, 16'hE000, 0,  0, 1, 0, 13'h002, 3'd7, 13'h000, 16'd2);
    add(0, 0, 0, 16'h0000, 0,  0, 0, 1, 13'h003, 3'd7, 13'h000, 16'd3);
    add(0, 0, 1, 16'h1234, 1,  0, 0, 1, 13'h003, 3'd7, 13'h000, 16'd3);
    // Restart from HALT; JMP 0x10 with three wait states and ignored start/ack
    add(0, 1, 0, 16'h0000, 0,  1, 0, 0, 13'h000, 3'd7, 13'h000, 16'd0);
    add(0, 1, 0, 16'h0000, 0,  1, 0, 0, 13'h000, 3'd7, 13'h000, 16'd0);
    add(0, 0, 0, 16'h0000, 0,  1, 0, 0, 13'h000, 3'd7, 13'h000, 16'd0);
    add(0, 0, 0, 16'h0000, 0,  1, 0, 0, 13'h000, 3'd7, 13'h000, 16'd0);
    add(0, 0, 1, 16'h8010, 0,  0, 1, 0, 13'h000, 3'd4, 13'h010, 16'd0);
    add(0, 1, 1, 16'hFFFF, 1,  1, 0, 0, 13'h010, 3'd4, 13'h010, 16'd1);
    add(0, 0, 1, 16'h0123, 0,  0, 1, 0, 13'h010, 3'd0, 13'h123, 16'd1);
    add(0, 0, 0, 16'h0000, 1,  1, 0, 0, 13'h123, 3'd0, 13'h123, 16'd2);
    add(0, 0, 0, 16'h0000, 1,  1, 0, 0, 13'h123, 3'd0, 13'h123, 16'd2);
    // Reset in a wait cycle, late ack, reset beating start, then fresh run from 0
    add(1, 0, 0, 16'h0000, 0,  0, 0, 0, 13'h000, 3'd0, 13'h000, 16'd0);
    add(0, 0, 1, 16'hFFFF, 0,  0, 0, 0, 13'h000, 3'd0, 13'h000, 16'd0);
    add(1, 1, 0, 16'h0000, 0,  0, 0, 0, 13'h000, 3'd0, 13'h000, 16'd0);
    add(0, 1, 0, 16'h0000, 0,  1, 0, 0, 13'h000, 3'd0, 13'h000, 16'd0);
    add(0, 0, 1, 16'h2001, 0,  0, 1, 0, 13'h000, 3'd1, 13'h001, 16'd0);
    add(0, 0, 0, 16'h0000, 0,  1, 0, 0, 13'h001, 3'd1, 13'h001, 16'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst;
      bus.start      = vecs[i].start;
      bus.imem_ack   = vecs[i].ack;
      bus.imem_rdata = vecs[i].rdata;
      bus.pc_src     = vecs[i].pc_src;
      @(posedge clk);
      #1;
      chk("imem_req", i, 32'(bus.imem_req), 32'(vecs[i].exp_req));
      chk("exec_en", i, 32'(bus.exec_en), 32'(vecs[i].exp_exec));
      chk("halted", i, 32'(bus.halted), 32'(vecs[i].exp_halted));
      chk("pc", i, 32'(bus.pc), 32'(vecs[i].exp_pc));
      chk("imem_addr", i, 32'(bus.imem_addr), 32'(vecs[i].exp_pc));
      chk("opcode", i, 32'(bus.opcode), 32'(vecs[i].exp_op));
      chk("operand", i, 32'(bus.operand), 32'(vecs[i].exp_opnd));
      chk("instr_count", i, 32'(bus.instr_count), 32'(vecs[i].exp_cnt));
    end

    // Wrap-around: start at 13'h1FFF, one sequential instruction, next fetch at 0
    @(posedge clk); #1;
    rst2 = 1'b0;
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    begin
      int budget;
      budget = 0;
      while (!bus2.imem_req && budget < 8) begin
        @(posedge clk); #1;
        budget++;
      end
      chk("wrap_req_seen", 100, 32'(bus2.imem_req), 32'd1);
    end
    chk("wrap_first_addr", 100, 32'(bus2.imem_addr), 32'h1FFF);
    bus2.imem_ack = 1'b1;
    bus2.imem_rdata = 16'h2055;
    @(posedge clk); #1;
    bus2.imem_ack = 1'b0;
    chk("wrap_exec", 101, 32'(bus2.exec_en), 32'd1);
    chk("wrap_operand", 101, 32'(bus2.operand), 32'h0055);
    @(posedge clk); #1;
    chk("wrap_next_req", 102, 32'(bus2.imem_req), 32'd1);
    chk("wrap_next_addr", 102, 32'(bus2.imem_addr), 32'h0000);
    chk("wrap_count", 102, 32'(bus2.instr_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
